// File: rtl/instruction_fetch.sv
// Fetch stage: drives ROM address from the PC, assembles 1/2-byte instructions and
// presents them over valid/ready. Optional self-loop halt enabled by FETCH_SELF_LOOP_HALT_EN.
module instruction_fetch #(
    parameter logic [7:0] RESET_PC = 8'd0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] address_bus,
    input  logic [7:0] data_bus,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_imm,
    output logic       instr_len2,
    output logic [7:0] instr_pc,
    input  logic       redirect_en,
    input  logic [7:0] redirect_addr,
    output logic       halted
);

    typedef enum logic [1:0] {
        ST_F0   = 2'd0,
        ST_F1   = 2'd1,
        ST_OUT  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] pc_r, pc_s;
    logic [7:0] opcode_r, opcode_s;
    logic [7:0] imm_r, imm_s;
    logic [7:0] ipc_r, ipc_s;
    logic       len2_r, len2_s;
    logic       valid_r, valid_s;
`ifdef FETCH_SELF_LOOP_HALT_EN
    logic       halted_r, halted_s;
`endif

    // MOV_IMM/CMP_IMM live at 8'h8x, the branches at 8'hAx-8'hBx
    function automatic logic is_two_byte(input logic [7:0] op);
        return (op[7:4] == 4'b1000) || (op[7:5] == 3'b101);
    endfunction

    // Next-state and next-output computation
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        opcode_s = opcode_r;
        imm_s    = imm_r;
        ipc_s    = ipc_r;
        len2_s   = len2_r;
        valid_s  = valid_r;
`ifdef FETCH_SELF_LOOP_HALT_EN
        halted_s = halted_r;
`endif
        if (redirect_en) begin
            // Redirect wins over everything, including an in-flight fetch
            pc_s    = redirect_addr;
            state_s = ST_F0;
            valid_s = 1'b0;
`ifdef FETCH_SELF_LOOP_HALT_EN
            halted_s = 1'b0;
`endif
        end else begin
            case (state_r)
                ST_F0: begin
                    opcode_s = data_bus;
                    ipc_s    = pc_r;
                    pc_s     = pc_r + 8'd1;
                    if (is_two_byte(data_bus)) begin
                        len2_s  = 1'b1;
                        state_s = ST_F1;
                    end else begin
                        len2_s  = 1'b0;
                        imm_s   = 8'd0;
                        state_s = ST_OUT;
                        valid_s = 1'b1;
                    end
                end
                ST_F1: begin
                    imm_s   = data_bus;
                    pc_s    = pc_r + 8'd1;
                    state_s = ST_OUT;
                    valid_s = 1'b1;
                end
                ST_OUT: begin
                    if (instr_ready) begin
                        valid_s = 1'b0;
`ifdef FETCH_SELF_LOOP_HALT_EN
                        if ((opcode_r == 8'hA8) && (imm_r == ipc_r)) begin
                            state_s  = ST_HALT;
                            halted_s = 1'b1;
                        end else begin
                            state_s = ST_F0;
                        end
`else
                        state_s = ST_F0;
`endif
                    end else begin
                        state_s = ST_OUT;
                    end
                end
`ifdef FETCH_SELF_LOOP_HALT_EN
                ST_HALT: begin
                    state_s = ST_HALT;
                    valid_s = 1'b0;
                end
`endif
                default: begin
                    state_s = ST_F0;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_F0;
            pc_r     <= RESET_PC;
            opcode_r <= 8'd0;
            imm_r    <= 8'd0;
            ipc_r    <= 8'd0;
            len2_r   <= 1'b0;
            valid_r  <= 1'b0;
`ifdef FETCH_SELF_LOOP_HALT_EN
            halted_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            opcode_r <= opcode_s;
            imm_r    <= imm_s;
            ipc_r    <= ipc_s;
            len2_r   <= len2_s;
            valid_r  <= valid_s;
`ifdef FETCH_SELF_LOOP_HALT_EN
            halted_r <= halted_s;
`endif
        end
    end

    assign address_bus  = pc_r;
    assign instr_valid  = valid_r;
    assign instr_opcode = opcode_r;
    assign instr_imm    = imm_r;
    assign instr_len2   = len2_r;
    assign instr_pc     = ipc_r;
`ifdef FETCH_SELF_LOOP_HALT_EN
    assign halted = halted_r;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed table-driven bench for instruction_fetch with a behavioural ROM.
module tb_instruction_fetch;

    logic       clk;
    logic       reset;
    logic [7:0] address_bus;
    logic [7:0] data_bus;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_imm;
    logic       instr_len2;
    logic [7:0] instr_pc;
    logic       redirect_en;
    logic [7:0] redirect_addr;
    logic       halted;

    logic [7:0] rom [256];
    int n_vec;
    int n_err;

    assign data_bus = rom[address_bus];

    instruction_fetch #(.RESET_PC(8'd0)) dut (
        .clk(clk), .reset(reset), .address_bus(address_bus), .data_bus(data_bus),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
        .instr_imm(instr_imm), .instr_len2(instr_len2), .instr_pc(instr_pc),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ready;
        logic       redir;
        logic [7:0] raddr;
        logic       ev;
        logic [7:0] eop;
        logic [7:0] eimm;
        logic       elen;
        logic [7:0] epc;
        logic [7:0] eaddr;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [7:0] eop,
                           input logic [7:0] eimm, input logic elen, input logic [7:0] epc,
                           input logic [7:0] eaddr, input logic ehalt);
        chk({tag, ".valid"},  {7'd0, instr_valid}, {7'd0, ev});
        chk({tag, ".opcode"}, instr_opcode, eop);
        chk({tag, ".imm"},    instr_imm, eimm);
        chk({tag, ".len2"},   {7'd0, instr_len2}, {7'd0, elen});
        chk({tag, ".pc"},     instr_pc, epc);
        chk({tag, ".addr"},   address_bus, eaddr);
        chk({tag, ".halted"}, {7'd0, halted}, {7'd0, ehalt});
    endtask

    task automatic step(input logic rdy, input logic rd, input logic [7:0] ra);
        instr_ready   = rdy;
        redirect_en   = rd;
        redirect_addr = ra;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0] = 8'h80; rom[1] = 8'h05; rom[2] = 8'h70; rom[3] = 8'h70;
        rom[4] = 8'hA0; rom[5] = 8'h33; rom[10] = 8'h85; rom[11] = 8'h77;
        rom[40] = 8'h0E; rom[255] = 8'hB4;
        rom[50] = 8'hA8; rom[51] = 8'd50;

        //            rdy   rd    raddr  v     op     imm    len   pc     addr
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h80, 8'h00, 1'b1, 8'h00, 8'h01};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h80, 8'h05, 1'b1, 8'h00, 8'h02};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h80, 8'h05, 1'b1, 8'h00, 8'h02};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h80, 8'h05, 1'b1, 8'h00, 8'h02};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h80, 8'h05, 1'b1, 8'h00, 8'h02};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h80, 8'h05, 1'b1, 8'h00, 8'h02};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h80, 8'h05, 1'b1, 8'h00, 8'h02};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h70, 8'h00, 1'b0, 8'h02, 8'h03};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h70, 8'h00, 1'b0, 8'h02, 8'h03};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h70, 8'h00, 1'b0, 8'h03, 8'h04};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h70, 8'h00, 1'b0, 8'h03, 8'h04};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'hA0, 8'h00, 1'b1, 8'h04, 8'h05};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hA0, 8'h33, 1'b1, 8'h04, 8'h06};
        tbl[13] = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'hA0, 8'h33, 1'b1, 8'h04, 8'hFF};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'hB4, 8'h33, 1'b1, 8'hFF, 8'h00};
        tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hB4, 8'h80, 1'b1, 8'hFF, 8'h01};
        tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'hB4, 8'h80, 1'b1, 8'hFF, 8'h01};
        tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 8'h00, 1'b0, 8'h01, 8'h02};
        tbl[18] = '{1'b1, 1'b1, 8'h0A, 1'b0, 8'h05, 8'h00, 1'b0, 8'h01, 8'h0A};
        tbl[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h85, 8'h00, 1'b1, 8'h0A, 8'h0B};
        tbl[20] = '{1'b1, 1'b1, 8'h28, 1'b0, 8'h85, 8'h00, 1'b1, 8'h0A, 8'h28};
        tbl[21] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h0E, 8'h00, 1'b0, 8'h28, 8'h29};

        reset = 1'b0;
        instr_ready = 1'b1;
        redirect_en = 1'b0;
        redirect_addr = 8'd0;
        repeat (2) @(negedge clk);
        chk_all("reset", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].ready, tbl[i].redir, tbl[i].raddr);
            chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eop, tbl[i].eimm,
                    tbl[i].elen, tbl[i].epc, tbl[i].eaddr, 1'b0);
        end

        // Async reset while presenting: must clear without waiting for a clock edge
        #2 reset = 1'b0;
        #1 chk_all("async_rst", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk_all("post_rst", 1'b1, 8'h80, 8'h05, 1'b1, 8'h00, 8'h02, 1'b0);

        // Wrap: 2-byte instruction at 255 takes its immediate from address 0
        rom[0] = 8'd9;
        step(1'b1, 1'b1, 8'hFF);
        chk("wrap.redir_addr", address_bus, 8'hFF);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk_all("wrap", 1'b1, 8'hB4, 8'd9, 1'b1, 8'hFF, 8'h01, 1'b0);

        // Self-branch at 50
        step(1'b1, 1'b1, 8'd50);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk_all("selfbra", 1'b1, 8'hA8, 8'd50, 1'b1, 8'd50, 8'd52, 1'b0);
        step(1'b1, 1'b0, 8'h00);
`ifdef FETCH_SELF_LOOP_HALT_EN
        chk_all("halt", 1'b0, 8'hA8, 8'd50, 1'b1, 8'd50, 8'd52, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'h00);
            chk_all($sformatf("halt_hold%0d", i), 1'b0, 8'hA8, 8'd50, 1'b1, 8'd50, 8'd52, 1'b1);
        end
        step(1'b1, 1'b1, 8'h00);
        chk("halt_exit.halted", {7'd0, halted}, 8'd0);
        chk("halt_exit.addr", address_bus, 8'h00);
`else
        chk_all("nohalt", 1'b0, 8'hA8, 8'd50, 1'b1, 8'd50, 8'd52, 1'b0);
        step(1'b1, 1'b0, 8'h00);
        chk_all("nohalt_next", 1'b1, 8'h00, 8'h00, 1'b0, 8'd52, 8'd53, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
